// File: rtl/delay_stream_serializer_if.sv
// Word-in / bit-out bundle between the delay bank, the serializer and downstream logic.
// master drives words and serial ready; slave is the serializer side.
interface delay_stream_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         data_in;
    logic                     dvalid;
    logic                     ser_ready;
    logic                     ser_out;
    logic                     ser_valid;
    logic                     ser_last;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    modport master (
        output data_in, dvalid, ser_ready,
        input  ser_out, ser_valid, ser_last, full, level, overflow
    );

    modport slave (
        input  data_in, dvalid, ser_ready,
        output ser_out, ser_valid, ser_last, full, level, overflow
    );
endinterface

// File: rtl/delay_stream_serializer.sv
// Buffers delay-bank words in a small FIFO and shifts each out LSB-first with valid/ready.
// state | meaning: IDLE | no word in the shifter; SHIFT | word in the shifter, bits offered
module delay_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    delay_stream_serializer_if.slave   s
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               push, pop;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        // Pushes are gated by the registered FULL, so a pop cannot rescue a word arriving when full.
        push      = s.dvalid && !full_q;

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    shift_d   = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (s.ser_ready) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else if (level_q != '0) begin
                        shift_d   = mem_q[rd_ptr_q];
                        pop       = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = s.data_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LW'(DEPTH));
        if (s.dvalid && full_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decode registers only; no input reaches them in the same cycle.
    assign s.ser_out   = shift_q[0];
    assign s.ser_valid = (state_q == SHIFT);
    assign s.ser_last  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign s.full      = full_q;
    assign s.level     = level_q;
    assign s.overflow  = ovf_q;
endmodule

// File: tb/tb_delay_stream_serializer.sv
// Bench for delay_stream_serializer: queue-based word model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_delay_stream_serializer;
    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic reset;
    delay_stream_serializer_if #(.WIDTH(W), .DEPTH(D)) intf ();

    delay_stream_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (intf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: FIFO is a queue of words, the shifter is a word plus a bit index.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_cur = '0;
    int           m_idx = 0;
    bit           m_busy = 1'b0;
    bit           m_ovf = 1'b0;

    always @(posedge clk) begin
        int  lvl;
        bit  was_full;
        lvl      = m_q.size();
        was_full = (lvl == D);
        if (reset) begin
            m_q.delete();
            m_cur  = '0;
            m_idx  = 0;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (!m_busy) begin
                if (lvl > 0) begin
                    m_cur  = m_q.pop_front();
                    m_idx  = 0;
                    m_busy = 1'b1;
                end
            end else if (intf.ser_ready) begin
                if (m_idx < W - 1) m_idx++;
                else if (lvl > 0) begin
                    m_cur = m_q.pop_front();
                    m_idx = 0;
                end else m_busy = 1'b0;
            end
            if (intf.dvalid) begin
                if (was_full) m_ovf = 1'b1;
                else m_q.push_back(intf.data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", 32'(intf.ser_valid), 32'(m_busy));
            chk("m_last", 32'(intf.ser_last), 32'(m_busy && (m_idx == W - 1)));
            if (m_busy) chk("m_ser_out", 32'(intf.ser_out), 32'(m_cur[m_idx]));
            chk("m_level", 32'(intf.level), 32'(m_q.size()));
            chk("m_full", 32'(intf.full), 32'(m_q.size() == D));
            chk("m_overflow", 32'(intf.overflow), 32'(m_ovf));
        end
    end

    // Rebuild accepted words from the serial handshake.
    logic [W-1:0] got[$];
    logic [W-1:0] acc = '0;
    int           acc_n = 0;

    always @(negedge clk) begin
        if (reset) begin
            acc_n = 0;
        end else if (intf.ser_valid && intf.ser_ready) begin
            if (acc_n < W) acc[acc_n] = intf.ser_out;
            acc_n++;
            if (intf.ser_last) begin
                got.push_back(acc);
                acc_n = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        intf.dvalid  = 1'b1;
        intf.data_in = w;
        @(posedge clk);
        #1;
        intf.dvalid  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk);
        while ((intf.ser_valid || intf.level != '0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_time", 32'(k < 500), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] exp_words[$];
        int k;
        int runs;
        int vcount;
        bit prev_v;

        reset          = 1'b1;
        intf.dvalid    = 1'b1;
        intf.data_in   = W'($urandom);
        intf.ser_ready = 1'b1;

        // Reset during traffic
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(intf.ser_valid), 32'd0);
        chk("rst_last", 32'(intf.ser_last), 32'd0);
        chk("rst_out", 32'(intf.ser_out), 32'd0);
        chk("rst_full", 32'(intf.full), 32'd0);
        chk("rst_level", 32'(intf.level), 32'd0);
        chk("rst_ovf", 32'(intf.overflow), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        intf.dvalid = 1'b0;
        @(posedge clk);
        #1;

        // Single word A5, ready high
        a5 = 8'hA5;
        send(a5);
        @(negedge clk);
        chk("sw_level_t1", 32'(intf.level), 32'd1);
        chk("sw_valid_t1", 32'(intf.ser_valid), 32'd0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("sw_valid", 32'(intf.ser_valid), 32'd1);
            chk("sw_bit", 32'(intf.ser_out), 32'(a5[i]));
            chk("sw_last", 32'(intf.ser_last), 32'(i == W - 1));
        end
        @(negedge clk);
        chk("sw_valid_end", 32'(intf.ser_valid), 32'd0);
        drain();

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        got.delete();
        intf.ser_ready = 1'b1;
        send(8'h3C);
        k = 0;
        while (got.size() < 1 && k < 100) begin
            intf.ser_ready = (k % 3 == 0);
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_done", 32'(k < 100), 32'd1);
        if (got.size() > 0) chk("bp_word", 32'(got[0]), 32'h3C);
        intf.ser_ready = 1'b1;
        drain();

        // Overflow: six words with downstream stalled
        got.delete();
        intf.ser_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(W'(i));
        @(negedge clk);
        chk("ov_level", 32'(intf.level), 32'd4);
        chk("ov_full", 32'(intf.full), 32'd1);
        chk("ov_flag", 32'(intf.overflow), 32'd1);
        @(posedge clk);
        #1;
        intf.ser_ready = 1'b1;
        runs = 0;
        vcount = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (intf.ser_valid) vcount++;
            if (intf.ser_valid && !prev_v) runs++;
            prev_v = intf.ser_valid;
        end
        chk("ov_valid_cycles", 32'(vcount), 32'd40);
        chk("ov_valid_runs", 32'(runs), 32'd1);
        chk("ov_flag_sticky", 32'(intf.overflow), 32'd1);
        exp_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk("ov_word_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("ov_word", 32'(got[i]), 32'(exp_words[i]));
        drain();

        // Push coinciding with a last-bit handshake at LEVEL=2
        got.delete();
        intf.ser_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        @(negedge clk);
        chk("pp_level_pre", 32'(intf.level), 32'd2);
        @(posedge clk);
        #1;
        intf.ser_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!intf.ser_last && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pp_found_last", 32'(k < 20), 32'd1);
        intf.dvalid  = 1'b1;
        intf.data_in = 8'h44;
        @(posedge clk);
        #1;
        intf.dvalid = 1'b0;
        @(negedge clk);
        chk("pp_level", 32'(intf.level), 32'd2);
        chk("pp_valid", 32'(intf.ser_valid), 32'd1);
        chk("pp_last", 32'(intf.ser_last), 32'd0);
        drain();
        exp_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("pp_word_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("pp_word", 32'(got[i]), 32'(exp_words[i]));

        // Reset mid-word, then a clean word
        got.delete();
        intf.ser_ready = 1'b0;
        send(8'hFF);
        send(8'h55);
        send(8'h66);
        intf.ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rm_valid", 32'(intf.ser_valid), 32'd0);
        chk("rm_level", 32'(intf.level), 32'd0);
        chk("rm_out", 32'(intf.ser_out), 32'd0);
        chk("rm_last", 32'(intf.ser_last), 32'd0);
        chk("rm_ovf", 32'(intf.overflow), 32'd0);
        send(8'h81);
        drain();
        chk("rm_word_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("rm_word", 32'(got[0]), 32'h81);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            intf.dvalid    = ($urandom_range(0, 99) < 45);
            intf.data_in   = W'($urandom);
            intf.ser_ready = ($urandom_range(0, 99) < 70);
            reset          = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #1;
        end
        reset          = 1'b0;
        intf.dvalid    = 1'b0;
        intf.ser_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
